seg7_scan_reader: RTL and testbench

- Reverse of the team's hex-to-7-segment decoder: watches a multiplexed, active-high 7-segment display bus and recovers the hex digit shown on each position.
- Use: the verification harness and on-board self-test loop back the display outputs and check what the board is actually driving.
- Per-position values are captured only after the segment and select lines have been stable for a programmable number of cycles.
- Each capture raises an update pulse carrying the digit index.

---
 rtl/seg7_scan_reader.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed active-high 7-segment bus.
// Each position is captured once its segment/select inputs hold stable.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   dig_valid,
    output logic [NUM_DIGITS-1:0]   dig_err,
    output logic                    upd,
    output logic [IDX_W-1:0]        upd_idx
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SW    = 8 + NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]             held_q, held_d;
    logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
    logic [NUM_DIGITS-1:0]     dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     valid_q, valid_d;
    logic [NUM_DIGITS-1:0]     err_q, err_d;
    logic                      upd_q, upd_d;
    logic [IDX_W-1:0]          idx_q, idx_d;

    logic [SW-1:0]    in_w;
    logic             onehot;
    logic             cap;
    logic [IDX_W-1:0] enc;
    logic [3:0]       dec_val;
    logic             dec_legal;
    logic             dec_blank;

    assign in_w   = {seg_in, dig_sel};
    assign onehot = (dig_sel != '0) &&
                    ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);

    always_comb begin
        enc = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel[i]) enc = IDX_W'(i);
        end
    end

    // Segment pattern {a..g} back to its hex value
    always_comb begin
        dec_val   = 4'h0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        unique case (seg_in[7:1])
            7'b1111110: dec_val = 4'h0;
            7'b0110000: dec_val = 4'h1;
            7'b1101101: dec_val = 4'h2;
            7'b1111001: dec_val = 4'h3;
            7'b0110011: dec_val = 4'h4;
            7'b1011011: dec_val = 4'h5;
            7'b1011111: dec_val = 4'h6;
            7'b1110000: dec_val = 4'h7;
            7'b1111111: dec_val = 4'h8;
            7'b1111011: dec_val = 4'h9;
            7'b1110111: dec_val = 4'hA;
            7'b0011111: dec_val = 4'hB;
            7'b1001110: dec_val = 4'hC;
            7'b0111101: dec_val = 4'hD;
            7'b1001111: dec_val = 4'hE;
            7'b1000111: dec_val = 4'hF;
            7'b0000000: dec_blank = 1'b1;
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        cap     = 1'b0;
        if (in_w != held_q) begin
            held_d = in_w;
            if (onehot) begin
                cnt_d = CNT_W'(1);
                if (STABLE_CYCLES == 1) begin
                    cap     = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COUNT;
                end
            end else begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_COUNT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_TGT) begin
                cap     = 1'b1;
                state_d = ST_DONE;
            end
        end
    end

    always_comb begin
        digits_d = digits_q;
        dp_d     = dp_q;
        valid_d  = valid_q;
        err_d    = err_q;
        upd_d    = cap;
        idx_d    = cap ? enc : idx_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap && dig_sel[i]) begin
                digits_d[4*i +: 4] = dec_legal ? dec_val : 4'h0;
                dp_d[i]            = seg_in[0];
                valid_d[i]         = dec_legal && !dec_blank;
                err_d[i]           = !dec_legal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            held_q   <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            held_q   <= held_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            upd_q    <= upd_d;
            idx_q    <= idx_d;
        end
    end

    assign digits    = digits_q;
    assign dp        = dp_q;
    assign dig_valid = valid_q;
    assign dig_err   = err_q;
    assign upd       = upd_q;
    assign upd_idx   = idx_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader: expected captures are queued
// by the stimulus and popped by a monitor on every upd pulse.
module tb_seg7_scan_reader;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    seg_in = 8'h00;
    logic [ND-1:0] dig_sel = '0;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] dp;
    logic [ND-1:0] dig_valid;
    logic [ND-1:0] dig_err;
    logic          upd;
    logic [1:0]    upd_idx;

    int nvec = 0;
    int nfail = 0;

    typedef struct {
        int         idx;
        logic [3:0] val;
        logic       dp;
        logic       v;
        logic       e;
    } exp_t;

    exp_t q[$];

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .digits    (digits),
        .dp        (dp),
        .dig_valid (dig_valid),
        .dig_err   (dig_err),
        .upd       (upd),
        .upd_idx   (upd_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_cap(input int idx, input logic [3:0] val,
                              input logic d, input logic v, input logic e);
        exp_t x;
        x.idx = idx;
        x.val = val;
        x.dp  = d;
        x.v   = v;
        x.e   = e;
        q.push_back(x);
    endtask

    // Inputs change on a falling edge and stay for n rising edges
    task automatic hold(input logic [7:0] s, input logic [ND-1:0] sel,
                        input int n);
        seg_in  = s;
        dig_sel = sel;
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (upd === 1'b1) begin
            if (q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL spurious_upd: got upd=1 idx=%0d expected no pulse",
                         upd_idx);
            end else begin
                exp_t x;
                x = q.pop_front();
                check("upd_idx", 32'(upd_idx), 32'(x.idx));
                check("cap_digit", 32'(digits[4*x.idx +: 4]), 32'(x.val));
                check("cap_dp", 32'(dp[x.idx]), 32'(x.dp));
                check("cap_valid", 32'(dig_valid[x.idx]), 32'(x.v));
                check("cap_err", 32'(dig_err[x.idx]), 32'(x.e));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_valid", 32'(dig_valid), 32'h0);
        check("rst_err", 32'(dig_err), 32'h0);
        check("rst_upd", 32'(upd), 32'h0);
        check("rst_idx", 32'(upd_idx), 32'h0);
        rst = 1'b0;

        hold(8'h00, 4'b0000, 10);
        check("idle_digits", 32'(digits), 32'h0);
        check("idle_valid", 32'(dig_valid), 32'h0);

        expect_cap(2, 4'h3, 1'b0, 1'b1, 1'b0);
        hold(8'b1111_0010, 4'b0100, 5);
        check("d2_val", 32'(digits[11:8]), 32'h3);

        hold(8'b1111_0010, 4'b0001, 2);
        check("no_cap_3", 32'(digits[3:0]), 32'h0);
        expect_cap(0, 4'h5, 1'b1, 1'b1, 1'b0);
        hold(8'b1011_0111, 4'b0001, 3);
        check("d0_val", 32'(digits[3:0]), 32'h5);
        check("d0_dp", 32'(dp[0]), 32'h1);
        check("d2_kept", 32'(digits[11:8]), 32'h3);

        expect_cap(3, 4'h0, 1'b0, 1'b0, 1'b1);
        hold(8'b1010_1010, 4'b1000, 3);
        check("d3_err", 32'(dig_err[3]), 32'h1);
        check("d3_valid", 32'(dig_valid[3]), 32'h0);

        hold(8'b1111_0010, 4'b0011, 10);
        expect_cap(1, 4'h0, 1'b0, 1'b0, 1'b0);
        hold(8'h00, 4'b0010, 3);
        check("d1_valid", 32'(dig_valid[1]), 32'h0);
        check("d1_err", 32'(dig_err[1]), 32'h0);
        check("valid_vec", 32'(dig_valid), 32'b0101);

        hold(8'b1110_1110, 4'b0001, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_digits", 32'(digits), 32'h0);
        check("mid_rst_valid", 32'(dig_valid), 32'h0);
        expect_cap(0, 4'hA, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("a_not_yet", 32'(digits[3:0]), 32'h0);
        check("a_pending", 32'(q.size()), 32'd1);
        @(negedge clk);
        check("a_val", 32'(digits[3:0]), 32'hA);
        repeat (4) @(negedge clk);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
